// File: rtl/barrier_lane_array_if.sv
// Handshake bundle between the parking controller and the barrier lane array:
// per-lane commands and sensors in, per-lane status and summary flags out.
interface barrier_lane_array_if #(
  parameter int NUM_LANES = 4
);
  localparam int CNT_W = $clog2(NUM_LANES + 1);

  logic [NUM_LANES-1:0]   open_req;
  logic [NUM_LANES-1:0]   close_req;
  logic [NUM_LANES-1:0]   vehicle_present;
  logic                   emergency;
  logic [NUM_LANES-1:0]   fault_clear;
  logic [2*NUM_LANES-1:0] lane_state;
  logic [NUM_LANES-1:0]   barrier_open;
  logic [NUM_LANES-1:0]   barrier_moving;
  logic [NUM_LANES-1:0]   fault;
  logic [CNT_W-1:0]       open_count;
  logic                   all_closed;

  modport master (
    output open_req, close_req, vehicle_present, emergency, fault_clear,
    input  lane_state, barrier_open, barrier_moving, fault, open_count, all_closed
  );

  modport slave (
    input  open_req, close_req, vehicle_present, emergency, fault_clear,
    output lane_state, barrier_open, barrier_moving, fault, open_count, all_closed
  );
endinterface

// File: rtl/barrier_lane_array.sv
// NUM_LANES independent barrier FSMs with timed travel, obstruction reversal, reversal fault
// latch and global emergency open. Optional auto-close in OPEN: define BARRIER_AUTO_CLOSE_EN.
module barrier_lane_array #(
  parameter int NUM_LANES        = 4,
  parameter int MOVE_CYCLES      = 50,
  parameter int OPEN_HOLD_CYCLES = 200,
  parameter int MAX_REVERSALS    = 3,
  parameter int TIMER_W          = 16
) (
  input  logic                clk,
  input  logic                reset,
  barrier_lane_array_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_LANES + 1);
  localparam int REV_W = $clog2(MAX_REVERSALS + 1);
  localparam logic [TIMER_W-1:0] MOVE_LAST = TIMER_W'(MOVE_CYCLES - 1);
  localparam logic [REV_W-1:0]   REV_LAST  = REV_W'(MAX_REVERSALS - 1);
  localparam logic [REV_W-1:0]   REV_MAX   = REV_W'(MAX_REVERSALS);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'b00,
    ST_OPENING = 2'b01,
    ST_OPEN    = 2'b10,
    ST_CLOSING = 2'b11
  } lane_state_e;

  if (NUM_LANES < 1 || MOVE_CYCLES < 2 || MAX_REVERSALS < 1 || OPEN_HOLD_CYCLES < 1 ||
      ((MOVE_CYCLES - 1) >> TIMER_W) != 0 ||
      ((OPEN_HOLD_CYCLES - 1) >> TIMER_W) != 0) begin : g_param_check
    $error("barrier_lane_array: parameter out of range");
  end

  lane_state_e          state_q [NUM_LANES];
  lane_state_e          state_d [NUM_LANES];
  logic [TIMER_W-1:0]   timer_q [NUM_LANES];
  logic [TIMER_W-1:0]   timer_d [NUM_LANES];
  logic [REV_W-1:0]     rev_q   [NUM_LANES];
  logic [REV_W-1:0]     rev_d   [NUM_LANES];
  logic [NUM_LANES-1:0] fault_q;
  logic [NUM_LANES-1:0] fault_d;
  logic                 close_cmd;
  logic [CNT_W-1:0]     open_cnt;
  logic                 none_open;

`ifdef BARRIER_AUTO_CLOSE_EN
  localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(OPEN_HOLD_CYCLES - 1);
  logic [TIMER_W-1:0]   hold_q  [NUM_LANES];
  logic [TIMER_W-1:0]   hold_d  [NUM_LANES];
`endif

  always_comb begin
    close_cmd = 1'b0;
    fault_d   = fault_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      rev_d[i]   = rev_q[i];
      close_cmd  = bus.close_req[i];
`ifdef BARRIER_AUTO_CLOSE_EN
      hold_d[i]  = '0;
`endif
      unique case (state_q[i])
        ST_CLOSED: begin
          if (bus.open_req[i] || bus.emergency) begin
            state_d[i] = ST_OPENING;
            timer_d[i] = '0;
          end
        end
        ST_OPENING: begin
          if (timer_q[i] == MOVE_LAST) begin
            state_d[i] = ST_OPEN;
            timer_d[i] = '0;
          end else begin
            timer_d[i] = timer_q[i] + TIMER_W'(1);
          end
        end
        ST_OPEN: begin
`ifdef BARRIER_AUTO_CLOSE_EN
          // Idle time only accrues while the lane is free to close; a waiting vehicle restarts it.
          if (bus.vehicle_present[i] || bus.open_req[i]) begin
            hold_d[i] = '0;
          end else if (bus.emergency || fault_q[i]) begin
            hold_d[i] = hold_q[i];
          end else if (hold_q[i] == HOLD_LAST) begin
            close_cmd = 1'b1;
          end else begin
            hold_d[i] = hold_q[i] + TIMER_W'(1);
          end
`endif
          if (close_cmd && !bus.open_req[i] && !bus.vehicle_present[i] &&
              !bus.emergency && !fault_q[i]) begin
            state_d[i] = ST_CLOSING;
            timer_d[i] = '0;
          end
        end
        ST_CLOSING: begin
          // Reversal reuses the distance already travelled so the arm returns from where it is.
          if (bus.vehicle_present[i] || bus.open_req[i] || bus.emergency) begin
            state_d[i] = ST_OPENING;
            timer_d[i] = MOVE_LAST - timer_q[i];
            if (bus.vehicle_present[i]) begin
              if (rev_q[i] != REV_MAX) rev_d[i] = rev_q[i] + REV_W'(1);
              if (rev_q[i] >= REV_LAST) fault_d[i] = 1'b1;
            end
          end else if (timer_q[i] == MOVE_LAST) begin
            state_d[i] = ST_CLOSED;
            timer_d[i] = '0;
            rev_d[i]   = '0;
          end else begin
            timer_d[i] = timer_q[i] + TIMER_W'(1);
          end
        end
        default: state_d[i] = ST_CLOSED;
      endcase
      if (bus.fault_clear[i]) begin
        fault_d[i] = 1'b0;
        rev_d[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= ST_CLOSED;
        timer_q[i] <= '0;
        rev_q[i]   <= '0;
      end
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rev_q   <= rev_d;
      fault_q <= fault_d;
    end
  end

`ifdef BARRIER_AUTO_CLOSE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) hold_q[i] <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  // Status is decoded from registered state only, so async reset clears it without a clock.
  always_comb begin
    open_cnt       = '0;
    none_open      = 1'b1;
    bus.lane_state = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      bus.lane_state[2*i +: 2] = state_q[i];
      bus.barrier_open[i]      = (state_q[i] == ST_OPEN);
      bus.barrier_moving[i]    = (state_q[i] == ST_OPENING) || (state_q[i] == ST_CLOSING);
      if (state_q[i] == ST_OPEN) open_cnt = open_cnt + CNT_W'(1);
      if (state_q[i] != ST_CLOSED) none_open = 1'b0;
    end
  end

  assign bus.fault      = fault_q;
  assign bus.open_count = open_cnt;
  assign bus.all_closed = none_open;
endmodule

// File: tb/tb_barrier_lane_array.sv
// Bench for barrier_lane_array: vector table, hand-written corner sequences and random
// stimulus, all compared against a travel-time reference model of each lane.
module tb_barrier_lane_array;
  localparam int NL   = 4;
  localparam int MC   = 4;
  localparam int MAXR = 2;
  localparam int OHC  = 8;
  localparam int TW   = 16;
  localparam int M_CLOSED = 0, M_OPENING = 1, M_OPEN = 2, M_CLOSING = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  barrier_lane_array_if #(.NUM_LANES(NL)) bus();

  barrier_lane_array #(
    .NUM_LANES(NL), .MOVE_CYCLES(MC), .OPEN_HOLD_CYCLES(OHC),
    .MAX_REVERSALS(MAXR), .TIMER_W(TW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: mode plus edges remaining until the end of travel.
  int m_mode [NL];
  int m_left [NL];
  int m_revs [NL];
  int m_idle [NL];
  bit m_flt  [NL];

  typedef struct {
    logic [3:0] op, cl, vp, fc;
    logic       em;
    logic [7:0] exp_ls;
    logic [3:0] exp_flt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_mode[i] = M_CLOSED; m_left[i] = 0; m_revs[i] = 0; m_idle[i] = 0; m_flt[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [NL-1:0] op = bus.open_req;
    logic [NL-1:0] cl = bus.close_req;
    logic [NL-1:0] vp = bus.vehicle_present;
    logic [NL-1:0] fc = bus.fault_clear;
    logic          em = bus.emergency;
    bit closecmd;
    for (int i = 0; i < NL; i++) begin
      case (m_mode[i])
        M_CLOSED: if (op[i] || em) begin m_mode[i] = M_OPENING; m_left[i] = MC; end
        M_OPENING: begin
          if (m_left[i] == 1) begin m_mode[i] = M_OPEN; m_idle[i] = 0; end
          else m_left[i]--;
        end
        M_OPEN: begin
          closecmd = cl[i];
`ifdef BARRIER_AUTO_CLOSE_EN
          if (vp[i] || op[i]) m_idle[i] = 0;
          else if (!em && !m_flt[i]) begin
            if (m_idle[i] + 1 >= OHC) closecmd = 1;
            else m_idle[i]++;
          end
`endif
          if (closecmd && !op[i] && !vp[i] && !em && !m_flt[i]) begin
            m_mode[i] = M_CLOSING; m_left[i] = MC; m_idle[i] = 0;
          end
        end
        default: begin
          if (vp[i] || op[i] || em) begin
            m_mode[i] = M_OPENING;
            m_left[i] = MC - m_left[i] + 1;
            if (vp[i]) begin
              m_revs[i]++;
              if (m_revs[i] >= MAXR) m_flt[i] = 1;
            end
          end else if (m_left[i] == 1) begin
            m_mode[i] = M_CLOSED; m_revs[i] = 0;
          end else m_left[i]--;
        end
      endcase
      if (fc[i]) begin m_flt[i] = 0; m_revs[i] = 0; end
    end
  endtask

  task automatic check_outputs();
    logic [2*NL-1:0] els;
    logic [NL-1:0]   eo, emv, ef;
    int              oc;
    logic            ac;
    oc = 0; ac = 1'b1;
    for (int i = 0; i < NL; i++) begin
      els[2*i +: 2] = 2'(m_mode[i]);
      eo[i]  = (m_mode[i] == M_OPEN);
      emv[i] = (m_mode[i] == M_OPENING) || (m_mode[i] == M_CLOSING);
      ef[i]  = m_flt[i];
      if (eo[i]) oc++;
      if (m_mode[i] != M_CLOSED) ac = 1'b0;
    end
    chk("lane_state", 32'(bus.lane_state), 32'(els));
    chk("barrier_open", 32'(bus.barrier_open), 32'(eo));
    chk("barrier_moving", 32'(bus.barrier_moving), 32'(emv));
    chk("fault", 32'(bus.fault), 32'(ef));
    chk("open_count", 32'(bus.open_count), 32'(oc));
    chk("all_closed", 32'(bus.all_closed), 32'(ac));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic set_in(input logic [3:0] op, input logic [3:0] cl, input logic [3:0] vp,
                        input logic em, input logic [3:0] fc);
    bus.open_req = op; bus.close_req = cl; bus.vehicle_present = vp;
    bus.emergency = em; bus.fault_clear = fc;
  endtask

  task automatic add(input logic [3:0] op, input logic [3:0] cl, input logic [3:0] vp,
                     input logic [7:0] ls);
    vec_t v;
    v.op = op; v.cl = cl; v.vp = vp; v.fc = 4'h0; v.em = 1'b0; v.exp_ls = ls; v.exp_flt = 4'h0;
    tbl.push_back(v);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_all_closed", 32'(bus.all_closed), 32'd1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Lane 0 open/close; lane 1 mirrored reversal and blocked close; ignored requests on lane 0.
    add(4'h1, 0, 0, 8'h01); add(0, 0, 0, 8'h01); add(0, 0, 0, 8'h01); add(0, 0, 0, 8'h01);
    add(0, 0, 0, 8'h02);    add(0, 0, 0, 8'h02); add(0, 4'h1, 0, 8'h03); add(0, 0, 0, 8'h03);
    add(0, 0, 0, 8'h03);    add(0, 0, 0, 8'h03); add(0, 0, 0, 8'h00);
    add(4'h2, 0, 0, 8'h04); add(0, 0, 0, 8'h04); add(0, 0, 0, 8'h04); add(0, 0, 0, 8'h04);
    add(0, 0, 0, 8'h08);    add(0, 4'h2, 0, 8'h0C); add(0, 0, 0, 8'h0C);
    add(0, 0, 4'h2, 8'h04); add(0, 0, 0, 8'h04); add(0, 0, 0, 8'h08);
    add(0, 4'h2, 4'h2, 8'h08); add(0, 4'h2, 0, 8'h0C);
    add(0, 0, 0, 8'h0C);    add(0, 0, 0, 8'h0C); add(0, 0, 0, 8'h0C); add(0, 0, 0, 8'h00);
    add(0, 4'hF, 0, 8'h00);
    add(4'h1, 0, 0, 8'h01); add(0, 4'h1, 0, 8'h01); add(0, 4'h1, 0, 8'h01);
    add(0, 4'h1, 0, 8'h01); add(0, 4'h1, 0, 8'h02); add(4'h1, 4'h1, 0, 8'h02);
    add(0, 4'h1, 0, 8'h03); add(0, 0, 0, 8'h03); add(0, 0, 0, 8'h03); add(0, 0, 0, 8'h03);
    add(0, 0, 0, 8'h00);

    set_in(0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    #12;
    check_outputs();
    chk("reset_all_closed", 32'(bus.all_closed), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    cycle();

    for (int k = 0; k < tbl.size(); k++) begin
      set_in(tbl[k].op, tbl[k].cl, tbl[k].vp, tbl[k].em, tbl[k].fc);
      cycle();
      chk($sformatf("tbl%0d_lane_state", k), 32'(bus.lane_state), 32'(tbl[k].exp_ls));
      chk($sformatf("tbl%0d_fault", k), 32'(bus.fault), 32'(tbl[k].exp_flt));
    end

    // Two obstruction reversals on lane 2 latch the fault.
    set_in(4'h4, 0, 0, 0, 0); cycle(); set_in(0, 0, 0, 0, 0); repeat (4) cycle();
    chk("l2_open", 32'(bus.lane_state[5:4]), 32'd2);
    set_in(0, 4'h4, 0, 0, 0); cycle();
    set_in(0, 0, 4'h4, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0);    cycle();
    chk("l2_one_reversal_no_fault", 32'(bus.fault[2]), 32'd0);
    chk("l2_reopened", 32'(bus.lane_state[5:4]), 32'd2);
    set_in(0, 4'h4, 0, 0, 0); cycle();
    set_in(0, 0, 4'h4, 0, 0); cycle();
    chk("l2_fault_set", 32'(bus.fault[2]), 32'd1);
    set_in(0, 4'h4, 0, 0, 0); repeat (6) cycle();
    chk("l2_fault_holds_open", 32'(bus.lane_state[5:4]), 32'd2);
    set_in(0, 0, 0, 0, 4'h4); cycle();
    chk("l2_fault_cleared", 32'(bus.fault[2]), 32'd0);
    set_in(0, 4'h4, 0, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0); repeat (3) cycle();
    chk("l2_still_closing", 32'(bus.lane_state[5:4]), 32'd3);
    cycle();
    chk("l2_closed", 32'(bus.lane_state[5:4]), 32'd0);

    // Emergency while lanes 0 and 3 are closing and lanes 1, 2 are closed.
    set_in(4'h9, 0, 0, 0, 0); cycle(); set_in(0, 0, 0, 0, 0); repeat (4) cycle();
    set_in(0, 4'h9, 0, 0, 0); cycle(); set_in(0, 0, 0, 0, 0); cycle();
    chk("emg_pre_closing", 32'(bus.lane_state), 32'hC3);
    set_in(0, 0, 0, 1, 0); cycle(); repeat (4) cycle();
    chk("emg_open_count", 32'(bus.open_count), 32'd4);
    chk("emg_all_open", 32'(bus.barrier_open), 32'hF);
    chk("emg_no_fault", 32'(bus.fault), 32'h0);
    set_in(0, 4'hF, 0, 1, 0); cycle();
    chk("emg_blocks_close", 32'(bus.open_count), 32'd4);
    set_in(0, 0, 0, 0, 0); repeat (3) cycle();
    chk("emg_release_stays_open", 32'(bus.open_count), 32'd4);
    set_in(0, 4'hF, 0, 0, 0); cycle(); set_in(0, 0, 0, 0, 0); repeat (4) cycle();
    chk("emg_then_all_closed", 32'(bus.all_closed), 32'd1);

    // Asynchronous reset in the middle of opening.
    set_in(4'hF, 0, 0, 0, 0); cycle(); set_in(0, 0, 0, 0, 0); cycle();
    chk("pre_reset_moving", 32'(bus.barrier_moving), 32'hF);
    async_reset();
    chk("async_reset_state", 32'(bus.lane_state), 32'h0);

    // Lane 0 left open with no vehicle.
    set_in(4'h1, 0, 0, 0, 0); cycle(); set_in(0, 0, 0, 0, 0); repeat (4) cycle();
    chk("hold_open_start", 32'(bus.lane_state[1:0]), 32'd2);
`ifdef BARRIER_AUTO_CLOSE_EN
    repeat (4) cycle();
    set_in(0, 0, 4'h1, 0, 0); cycle(); set_in(0, 0, 0, 0, 0);
    repeat (7) cycle();
    chk("auto_close_restarted", 32'(bus.lane_state[1:0]), 32'd2);
    cycle();
    chk("auto_close_fires", 32'(bus.lane_state[1:0]), 32'd3);
    repeat (4) cycle();
`else
    repeat (100) cycle();
    chk("no_auto_close", 32'(bus.lane_state[1:0]), 32'd2);
    set_in(0, 4'h1, 0, 0, 0); cycle(); set_in(0, 0, 0, 0, 0); repeat (4) cycle();
`endif
    chk("hold_lane_closed", 32'(bus.all_closed), 32'd1);

    // Randomized traffic against the model, with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] op, cl, vp, fc;
      for (int i = 0; i < NL; i++) begin
        op[i] = ($urandom_range(0, 7) == 0);
        cl[i] = ($urandom_range(0, 3) == 0);
        vp[i] = ($urandom_range(0, 5) == 0);
        fc[i] = ($urandom_range(0, 39) == 0);
      end
      set_in(op, cl, vp, ($urandom_range(0, 39) == 0), fc);
      cycle();
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
